// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encoding and tick-counter width.
package rst_seq_pkg;

  localparam int TICK_CNT_W = 16;

  typedef logic [TICK_CNT_W-1:0] tick_cnt_t;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_e;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous bit, cleared by the async reset.
module sync2 (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-domain reset release: waits for PLL lock, holds all domains,
// then releases them one by one on prescaled ticks.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_DOMAINS   = 3,
  parameter int PRESCALE_BITS = 8,
  parameter int HOLD_TICKS    = 16,
  parameter int STAGGER_TICKS = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pll_locked,
  input  logic                   ext_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   tick_o,
  output logic                   ready_o,
  output logic [1:0]             state_o
);

  localparam logic [PRESCALE_BITS-1:0] PRESC_ONE    = PRESCALE_BITS'(1);
  localparam tick_cnt_t                HOLD_LAST    = tick_cnt_t'(HOLD_TICKS - 1);
  localparam tick_cnt_t                STAGGER_LAST = tick_cnt_t'(STAGGER_TICKS - 1);
  localparam logic [NUM_DOMAINS-1:0]   ALL_RST      = '1;

  function automatic tick_cnt_t sat_inc(input tick_cnt_t v);
    return (v == '1) ? v : v + tick_cnt_t'(1);
  endfunction

  logic                     lock_s;
  logic [PRESCALE_BITS-1:0] presc;
  logic [PRESCALE_BITS-1:0] presc_nxt;
  logic [NUM_DOMAINS-1:0]   rst_shift;
  state_e                   state;
  tick_cnt_t                tick_cnt;

  sync2 u_lock_sync (
    .clock (clock),
    .reset (reset),
    .d     (pll_locked),
    .q     (lock_s)
  );

  // tick_o is registered one cycle ahead so it is high while the count is all-ones
  assign presc_nxt = presc + PRESC_ONE;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      tick_o <= 1'b0;
    end else begin
      presc  <= presc_nxt;
      tick_o <= (presc_nxt == '1);
    end
  end

  // Releasing a domain shifts a zero in from bit 0; all-zero means every domain is out
  assign rst_shift = rst_o << 1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= WAIT_LOCK;
      rst_o    <= ALL_RST;
      ready_o  <= 1'b0;
      tick_cnt <= '0;
    end else if (!lock_s && state != WAIT_LOCK) begin
      state    <= WAIT_LOCK;
      rst_o    <= ALL_RST;
      ready_o  <= 1'b0;
      tick_cnt <= '0;
    end else if (ext_rst_req && state != WAIT_LOCK) begin
      state    <= HOLD;
      rst_o    <= ALL_RST;
      ready_o  <= 1'b0;
      tick_cnt <= '0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          rst_o   <= ALL_RST;
          ready_o <= 1'b0;
          if (lock_s) begin
            state    <= HOLD;
            tick_cnt <= '0;
          end
        end
        HOLD, RELEASE: begin
          if (tick_o) begin
            if (tick_cnt == ((state == HOLD) ? HOLD_LAST : STAGGER_LAST)) begin
              rst_o    <= rst_shift;
              tick_cnt <= '0;
              if (rst_shift == '0) begin
                state   <= RUN;
                ready_o <= 1'b1;
              end else begin
                state <= RELEASE;
              end
            end else begin
              tick_cnt <= sat_inc(tick_cnt);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Scoreboard bench: stimulus queues timestamped output changes, a monitor checks each change.
module tb_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       pll_locked;
  logic       ext_rst_req;
  logic [2:0] rst_o;
  logic       tick_o;
  logic       ready_o;
  logic [1:0] state_o;

  reset_sequencer #(
    .NUM_DOMAINS   (3),
    .PRESCALE_BITS (2),
    .HOLD_TICKS    (3),
    .STAGGER_TICKS (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pll_locked  (pll_locked),
    .ext_rst_req (ext_rst_req),
    .rst_o       (rst_o),
    .tick_o      (tick_o),
    .ready_o     (ready_o),
    .state_o     (state_o)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) if (!reset) cyc <= cyc + 1;

  typedef struct packed {
    int         c;
    logic [2:0] r;
    logic       rd;
    logic [1:0] s;
  } ev_t;

  ev_t exp_q[$];
  int  tick_q[$];
  int  n_vec  = 0;
  int  n_miss = 0;

  task automatic push_ev(input int c, input logic [2:0] r, input logic rd, input logic [1:0] s);
    ev_t e;
    e.c = c; e.r = r; e.rd = rd; e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic at_cyc(input int n);
    @(negedge clock);
    while (cyc < n) @(negedge clock);
  endtask

  initial begin : monitor
    logic [5:0] prev;
    logic [5:0] cur;
    ev_t        e;
    int         tc;
    prev = 'x;
    #2;
    forever begin
      @(negedge clock or posedge reset);
      #1;
      cur = {rst_o, ready_o, state_o};
      if (cur !== prev) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_miss++;
          $display("FAIL unexpected_change cyc=%0d got rst=%b rdy=%b st=%0d, required no change",
                   cyc, rst_o, ready_o, state_o);
        end else begin
          e = exp_q.pop_front();
          if (e.c != cyc || cur !== {e.r, e.rd, e.s}) begin
            n_miss++;
            $display("FAIL output_event got cyc=%0d rst=%b rdy=%b st=%0d, required cyc=%0d rst=%b rdy=%b st=%0d",
                     cyc, rst_o, ready_o, state_o, e.c, e.r, e.rd, e.s);
          end
        end
        prev = cur;
      end
      if (cyc >= 1 && cyc <= 24 && tick_o === 1'b1) begin
        n_vec++;
        if (tick_q.size() == 0) begin
          n_miss++;
          $display("FAIL tick_extra got tick at cyc=%0d, required none", cyc);
        end else begin
          tc = tick_q.pop_front();
          if (tc != cyc) begin
            n_miss++;
            $display("FAIL tick_cycle got tick at cyc=%0d, required cyc=%0d", cyc, tc);
          end
        end
      end
    end
  end

  initial begin : stimulus
    reset       = 1'b1;
    pll_locked  = 1'b0;
    ext_rst_req = 1'b0;
    push_ev(0, 3'b111, 1'b0, 2'd0);
    for (int k = 3; k <= 23; k += 4) tick_q.push_back(k);
    #22 reset = 1'b0;

    // lock acquired: sync, HOLD, then staggered release
    at_cyc(16); pll_locked = 1'b1;
    push_ev(19, 3'b111, 1'b0, 2'd1);
    push_ev(28, 3'b110, 1'b0, 2'd2);
    push_ev(36, 3'b100, 1'b0, 2'd2);
    push_ev(44, 3'b000, 1'b1, 2'd3);

    // one-clock lock glitch in RUN
    at_cyc(50); pll_locked = 1'b0;
    push_ev(53, 3'b111, 1'b0, 2'd0);
    push_ev(54, 3'b111, 1'b0, 2'd1);
    push_ev(64, 3'b110, 1'b0, 2'd2);
    push_ev(72, 3'b100, 1'b0, 2'd2);
    push_ev(80, 3'b000, 1'b1, 2'd3);
    at_cyc(51); pll_locked = 1'b1;

    // soft reset pulse in RUN
    at_cyc(84); ext_rst_req = 1'b1;
    push_ev(85,  3'b111, 1'b0, 2'd1);
    push_ev(96,  3'b110, 1'b0, 2'd2);
    push_ev(104, 3'b100, 1'b0, 2'd2);
    at_cyc(85); ext_rst_req = 1'b0;

    // soft reset pulse in RELEASE with rst_o=100
    at_cyc(105); ext_rst_req = 1'b1;
    push_ev(106, 3'b111, 1'b0, 2'd1);
    push_ev(116, 3'b110, 1'b0, 2'd2);
    push_ev(124, 3'b100, 1'b0, 2'd2);
    push_ev(132, 3'b000, 1'b1, 2'd3);
    at_cyc(106); ext_rst_req = 1'b0;

    // held soft reset keeps restarting HOLD
    at_cyc(136); ext_rst_req = 1'b1;
    push_ev(137, 3'b111, 1'b0, 2'd1);
    push_ev(160, 3'b110, 1'b0, 2'd2);
    push_ev(168, 3'b100, 1'b0, 2'd2);
    push_ev(176, 3'b000, 1'b1, 2'd3);
    at_cyc(150); ext_rst_req = 1'b0;

    // lock loss and soft reset coincide at the FSM: lock loss wins
    at_cyc(180); pll_locked = 1'b0;
    at_cyc(182); ext_rst_req = 1'b1;
    push_ev(183, 3'b111, 1'b0, 2'd0);
    at_cyc(183); ext_rst_req = 1'b0;

    // soft reset ignored in WAIT_LOCK
    at_cyc(186); ext_rst_req = 1'b1;
    at_cyc(188); ext_rst_req = 1'b0;

    // relock, then async reset mid-RELEASE between clock edges
    at_cyc(190); pll_locked = 1'b1;
    push_ev(193, 3'b111, 1'b0, 2'd1);
    push_ev(204, 3'b110, 1'b0, 2'd2);
    push_ev(212, 3'b100, 1'b0, 2'd2);
    at_cyc(214);
    push_ev(214, 3'b111, 1'b0, 2'd0);
    #3 reset = 1'b1;

    repeat (5) @(negedge clock);
    #2;
    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL missing_event got no change, required cyc=%0d rst=%b rdy=%b st=%0d",
               e.c, e.r, e.rd, e.s);
    end
    while (tick_q.size() > 0) begin
      int tc;
      tc = tick_q.pop_front();
      n_vec++;
      n_miss++;
      $display("FAIL missing_tick got no tick, required tick at cyc=%0d", tc);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
